// File: rtl/game_pkg.sv
// Shared types and helpers for the 2048 game-state engine: tile exponent width,
// move directions, FSM states, exponent-to-literal conversion and line addressing.
package game_pkg;

  localparam int                 EXP_W   = 4;
  localparam logic [EXP_W-1:0]   MAX_EXP = 4'd11;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  typedef enum logic [2:0] {INIT, IDLE, SLIDE, SPAWN, CHECK} state_t;

  function automatic logic [11:0] exp_to_number(input logic [EXP_W-1:0] e);
    return (e == '0) ? 12'd0 : (12'd1 << e);
  endfunction

  // Cell index {row, col} of element pos of the given line; element 0 is the edge tiles slide toward.
  function automatic logic [3:0] line_index(input dir_t dir, input logic [1:0] line,
                                            input logic [1:0] pos);
    logic [3:0] idx;
    case (dir)
      UP:      idx = {pos, line};
      DOWN:    idx = {~pos, line};
      LEFT:    idx = {line, pos};
      default: idx = {line, ~pos};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational 2048 line rule: compress toward element 0, merge equal pairs outward once each.
module line_merge
  import game_pkg::*;
(
  input  logic [3:0][EXP_W-1:0] line_i,
  output logic [3:0][EXP_W-1:0] line_o,
  output logic                  changed_o,
  output logic [15:0]           score_inc_o,
  output logic                  made_2048_o
);

  // One spare trailing slot that stays empty, so the pair compare never reads past the line.
  logic [4:0][EXP_W-1:0] comp;
  logic [2:0]            n;
  logic [2:0]            k;
  logic                  skip;

  // NOTE: every output and temporary gets a default at the top so no path leaves a latch.
  always_comb begin
    comp        = '0;
    line_o      = '0;
    score_inc_o = '0;
    made_2048_o = 1'b0;
    n           = '0;
    k           = '0;
    skip        = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (line_i[i] != '0) begin
        comp[n] = line_i[i];
        n       = n + 3'd1;
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[3'(i) + 3'd1] && comp[i] != MAX_EXP) begin
          line_o[k[1:0]] = comp[i] + 4'd1;
          score_inc_o    = score_inc_o + (16'd1 << (comp[i] + 4'd1));
          made_2048_o    = made_2048_o | ((comp[i] + 4'd1) == MAX_EXP);
          skip           = 1'b1;
        end else begin
          line_o[k[1:0]] = comp[i];
        end
        k = k + 3'd1;
      end
    end

    changed_o = (line_o != line_i);
  end

endmodule

// File: rtl/game_board.sv
// 2048 game-state engine: board of tile exponents, move FSM, LFSR tile spawner and flags.
// Define BOARD_SCORE_EN to build the saturating score counter; otherwise score reads 0.
module game_board
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [3:0]  SPAWN4_MSK = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        ld_en,
  input  logic [3:0]  ld_idx,
  input  logic [3:0]  ld_exp,
  input  logic [3:0]  rd_idx,
  output logic [11:0] rd_number,
  output logic        busy,
  output logic [15:0] score,
  output logic        game_won,
  output logic        game_over
);

  state_t                 state_q, state_d;
  logic [15:0][EXP_W-1:0] board_q, board_d;
  logic [15:0]            lfsr_q;
  dir_t                   dir_q, dir_d, dir_sel;
  logic [1:0]             line_q, line_d;
  logic                   moved_q, moved_d;
  logic [3:0]             ptr_q, ptr_d;
  logic                   spawn2_q, spawn2_d;
  logic                   won_q, won_d;
  logic                   over_q, over_d;
  logic                   busy_q;
  logic [11:0]            rd_number_q;

  logic [3:0][EXP_W-1:0]  line_in, line_out;
  logic                   line_changed, made_2048, btn_any, can_move;
  logic [15:0]            score_inc;
  logic [EXP_W-1:0]       spawn_exp;

  always_comb begin
    for (int p = 0; p < 4; p++) line_in[p] = board_q[line_index(dir_q, line_q, 2'(p))];
  end

  line_merge u_line_merge (
    .line_i      (line_in),
    .line_o      (line_out),
    .changed_o   (line_changed),
    .score_inc_o (score_inc),
    .made_2048_o (made_2048)
  );

  assign btn_any   = btn_up | btn_down | btn_left | btn_right;
  assign dir_sel   = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : RIGHT;
  assign spawn_exp = (lfsr_q[7:4] == SPAWN4_MSK) ? 4'd2 : 4'd1;

  always_comb begin
    can_move = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[4'(r*4 + c)] == '0) can_move = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[4'(r*4 + c)] == board_q[4'(r*4 + c + 1)]) can_move = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[4'(r*4 + c)] == board_q[4'(r*4 + c + 4)]) can_move = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    dir_d    = dir_q;
    line_d   = line_q;
    moved_d  = moved_q;
    ptr_d    = ptr_q;
    spawn2_d = spawn2_q;
    won_d    = won_q;
    over_d   = over_q;
    case (state_q)
      INIT: begin
        ptr_d    = lfsr_q[3:0];
        spawn2_d = 1'b1;
        moved_d  = 1'b0;
        state_d  = SPAWN;
      end
      IDLE: begin
        if (ld_en) board_d[ld_idx] = (ld_exp > MAX_EXP) ? MAX_EXP : ld_exp;
        if (btn_any && !over_q) begin
          dir_d   = dir_sel;
          line_d  = '0;
          moved_d = 1'b0;
          state_d = SLIDE;
        end
      end
      SLIDE: begin
        for (int p = 0; p < 4; p++) board_d[line_index(dir_q, line_q, 2'(p))] = line_out[p];
        moved_d = moved_q | line_changed;
        won_d   = won_q | made_2048;
        line_d  = line_q + 2'd1;
        if (line_q == 2'd3) begin
          ptr_d    = lfsr_q[3:0];
          spawn2_d = 1'b0;
          state_d  = (moved_q | line_changed) ? SPAWN : IDLE;
        end
      end
      SPAWN: begin
        if (board_q[ptr_q] == '0) begin
          board_d[ptr_q] = spawn_exp;
          if (spawn2_q) begin
            spawn2_d = 1'b0;
            ptr_d    = lfsr_q[3:0];
          end else begin
            // Only a move reaches here with moved_q set; the reset-time spawns go straight to IDLE.
            state_d = moved_q ? CHECK : IDLE;
          end
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end
      CHECK: begin
        over_d  = over_q | ~can_move;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: board_q is a small register file rather than a RAM, so it clears with the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      board_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      dir_q       <= UP;
      line_q      <= '0;
      moved_q     <= 1'b0;
      ptr_q       <= '0;
      spawn2_q    <= 1'b0;
      won_q       <= 1'b0;
      over_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_number_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      board_q     <= board_d;
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dir_q       <= dir_d;
      line_q      <= line_d;
      moved_q     <= moved_d;
      ptr_q       <= ptr_d;
      spawn2_q    <= spawn2_d;
      won_q       <= won_d;
      over_q      <= over_d;
      busy_q      <= (state_d != IDLE);
      rd_number_q <= exp_to_number(board_q[rd_idx]);
    end
  end

`ifdef BOARD_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum;

  assign score_sum = {1'b0, score_q} + {1'b0, score_inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (state_q == SLIDE) begin
      score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  assign score = score_q;
`else
  logic unused_score_inc;
  assign unused_score_inc = ^score_inc;
  assign score            = 16'h0000;
`endif

  assign rd_number = rd_number_q;
  assign busy      = busy_q;
  assign game_won  = won_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_game_board.sv
// Self-checking bench for game_board: scenario tasks plus random moves against a queue-based
// model of the 2048 line rule; score expectations follow the BOARD_SCORE_EN build option.
module tb_game_board;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_idx = '0, ld_exp = '0, rd_idx = '0;
  logic [11:0] rd_number;
  logic        busy;
  logic [15:0] score;
  logic        game_won, game_over;

  int vectors = 0;
  int miscompares = 0;

  int model_b [16];
  int exp_b   [16];
  int act_b   [16];
  int ld_buf  [16];
  int model_score;
  bit model_won, model_over;
  int mv_inc;
  bit mv_chg, mv_won;

  game_board dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_exp    (ld_exp),
    .rd_idx    (rd_idx),
    .rd_number (rd_number),
    .busy      (busy),
    .score     (score),
    .game_won  (game_won),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Board cell visited at position p of line l when sliding in direction d (0 up,1 down,2 left,3 right).
  function automatic int cell_of(input int d, input int l, input int p);
    case (d)
      0:       return p * 4 + l;
      1:       return (3 - p) * 4 + l;
      2:       return l * 4 + p;
      default: return l * 4 + (3 - p);
    endcase
  endfunction

  function automatic void model_move(input int d);
    int q[$];
    int r[$];
    int a;
    mv_inc = 0;
    mv_chg = 0;
    mv_won = 0;
    for (int l = 0; l < 4; l++) begin
      q.delete();
      r.delete();
      for (int p = 0; p < 4; p++)
        if (model_b[cell_of(d, l, p)] != 0) q.push_back(model_b[cell_of(d, l, p)]);
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a && a < 11) begin
          void'(q.pop_front());
          r.push_back(a + 1);
          mv_inc += 1 << (a + 1);
          if (a + 1 == 11) mv_won = 1;
        end else begin
          r.push_back(a);
        end
      end
      while (r.size() < 4) r.push_back(0);
      for (int p = 0; p < 4; p++) begin
        exp_b[cell_of(d, l, p)] = r[p];
        if (r[p] != model_b[cell_of(d, l, p)]) mv_chg = 1;
      end
    end
  endfunction

  function automatic bit board_stuck();
    for (int i = 0; i < 16; i++) if (model_b[i] == 0) return 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (c < 3 && model_b[r*4 + c] == model_b[r*4 + c + 1]) return 0;
        if (r < 3 && model_b[r*4 + c] == model_b[(r+1)*4 + c]) return 0;
      end
    return 1;
  endfunction

  function automatic int num_to_exp(input logic [11:0] v);
    if (v == 12'd0) return 0;
    for (int e = 1; e < 12; e++) if (v == (12'd1 << e)) return e;
    return 99;
  endfunction

  function automatic int expected_score();
`ifdef BOARD_SCORE_EN
    return model_score;
`else
    return 0;
`endif
  endfunction

  task automatic read_board();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) act_b[i-1] = num_to_exp(rd_number);
      if (i < 16) rd_idx = 4'(i);
    end
  endtask

  task automatic load_board();
    int diffs;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en      = 1'b1;
      ld_idx     = 4'(i);
      ld_exp     = 4'(ld_buf[i]);
      model_b[i] = (ld_buf[i] > 11) ? 11 : ld_buf[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    read_board();
    diffs = 0;
    for (int i = 0; i < 16; i++) if (act_b[i] != model_b[i]) diffs++;
    vectors++;
    if (diffs != 0) begin
      miscompares++;
      $display("FAIL load_readback: %0d cells differ, required 0", diffs);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    int n, tiles, badv;
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || game_won !== 1'b0 || game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%b won=%b over=%b, required 0 0 0", busy, game_won, game_over);
    end
    vectors++;
    if (score !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_score: got %h, required 0000", score);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (rd_number !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_rd_number: got %h, required 000", rd_number);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL init_busy: got %b, required 1", busy);
    end
    wait_idle(n);
    vectors++;
    if (n >= 64) begin
      miscompares++;
      $display("FAIL init_done: busy still high after %0d cycles", n);
    end
    read_board();
    tiles = 0;
    badv  = 0;
    for (int i = 0; i < 16; i++)
      if (act_b[i] != 0) begin
        tiles++;
        if (act_b[i] != 1 && act_b[i] != 2) badv++;
      end
    vectors++;
    if (tiles != 2 || badv != 0) begin
      miscompares++;
      $display("FAIL init_spawn: %0d tiles (%0d not 2/4), required 2 tiles of 2/4", tiles, badv);
    end
    model_b     = act_b;
    model_score = 0;
    model_won   = 0;
    model_over  = 0;
  endtask

  // mask bit0 up, bit1 down, bit2 left, bit3 right
  task automatic run_move(input logic [3:0] mask);
    int  d, n, diffs, bad;
    bit  ok;
    d = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
    if (model_over) begin
      exp_b  = model_b;
      mv_chg = 0;
      mv_inc = 0;
      mv_won = 0;
    end else begin
      model_move(d);
    end
    @(negedge clk);
    {btn_right, btn_left, btn_down, btn_up} = mask;
    @(posedge clk);
    #1;
    {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
    wait_idle(n);
    ok = model_over ? (n == 0) : mv_chg ? (n >= 6 && n <= 21) : (n == 4);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL busy_cycles: dir %0d got %0d cycles, required %s", d, n,
               model_over ? "0" : mv_chg ? "6..21" : "4");
    end
    read_board();
    diffs = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++)
      if (act_b[i] != exp_b[i]) begin
        diffs++;
        if (!(mv_chg && exp_b[i] == 0 && (act_b[i] == 1 || act_b[i] == 2))) bad++;
      end
    vectors++;
    if (bad != 0 || diffs != (mv_chg ? 1 : 0)) begin
      miscompares++;
      $display("FAIL board_after_move: dir %0d, %0d wrong cells and %0d changed cells, required 0 wrong and %0d spawned",
               d, bad, diffs, mv_chg ? 1 : 0);
    end
    model_b = act_b;
    if (mv_chg) begin
      model_score = (model_score + mv_inc > 65535) ? 65535 : model_score + mv_inc;
      model_won   = model_won | mv_won;
      model_over  = board_stuck();
    end
    vectors++;
    if (score !== 16'(expected_score())) begin
      miscompares++;
      $display("FAIL score: got %0d, required %0d", score, expected_score());
    end
    vectors++;
    if (game_won !== model_won || game_over !== model_over) begin
      miscompares++;
      $display("FAIL flags: won=%b over=%b, required won=%b over=%b", game_won, game_over,
               model_won, model_over);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_merge_rows();
    ld_buf = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_board();
    run_move(4'b0100);
    vectors++;
    if (act_b[0] != 2 || act_b[1] != 2) begin
      miscompares++;
      $display("FAIL row_2222: cells 0,1 exps %0d,%0d, required 2,2", act_b[0], act_b[1]);
    end
    ld_buf = '{1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_board();
    run_move(4'b0100);
    vectors++;
    if (act_b[0] != 2 || act_b[1] != 2) begin
      miscompares++;
      $display("FAIL row_2024: cells 0,1 exps %0d,%0d, required 2,2", act_b[0], act_b[1]);
    end
  endtask

  task automatic test_no_change();
    int n;
    ld_buf = '{1, 0, 0, 0, 2, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0};
    load_board();
    run_move(4'b0100);
    // A second no-op move with a load and a right press arriving mid-slide: both must be dropped.
    @(negedge clk);
    btn_left = 1'b1;
    @(posedge clk);
    #1;
    btn_left = 1'b0;
    @(negedge clk);
    ld_en     = 1'b1;
    ld_idx    = 4'd5;
    ld_exp    = 4'd3;
    btn_right = 1'b1;
    @(posedge clk);
    #1;
    ld_en     = 1'b0;
    btn_right = 1'b0;
    wait_idle(n);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_btn: busy=%b after no-op move, required 0", busy);
    end
    read_board();
    n = 0;
    for (int i = 0; i < 16; i++) if (act_b[i] != model_b[i]) n++;
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL drop_ld: %0d cells changed, required 0", n);
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 40; it++) begin
      if (it % 5 == 0) begin
        for (int i = 0; i < 16; i++) begin
          r         = $urandom_range(0, 15);
          ld_buf[i] = (r < 7) ? 0 : (r < 14) ? $urandom_range(1, 9) : $urandom_range(11, 15);
        end
        load_board();
      end
      run_move(4'($urandom_range(1, 15)));
      if (model_over) do_reset();
    end
  endtask

  task automatic test_win();
    ld_buf = '{10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_board();
    run_move(4'b0100);
    vectors++;
    if (game_won !== 1'b1) begin
      miscompares++;
      $display("FAIL won_flag: got %b, required 1", game_won);
    end
    @(negedge clk);
    rd_idx = 4'd0;
    @(negedge clk);
    vectors++;
    if (rd_number !== 12'h800) begin
      miscompares++;
      $display("FAIL rd_2048: got %h, required 800", rd_number);
    end
    run_move(4'b1000);
  endtask

  task automatic test_reset_mid_slide();
    ld_buf = '{1, 1, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 3, 3, 0, 0};
    load_board();
    @(negedge clk);
    btn_left = 1'b1;
    @(posedge clk);
    #1;
    btn_left = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_reset();
  endtask

  task automatic test_game_over();
    ld_buf = '{7, 8, 7, 0, 3, 4, 3, 4, 4, 3, 4, 3, 3, 4, 3, 4};
    load_board();
    run_move(4'b1000);
    vectors++;
    if (game_over !== 1'b1) begin
      miscompares++;
      $display("FAIL over_flag: got %b, required 1", game_over);
    end
    run_move(4'b0001);
    run_move(4'b0100);
  endtask

  initial begin
    #2;
    test_reset();
    test_merge_rows();
    test_no_change();
    test_random();
    test_win();
    test_reset_mid_slide();
    test_game_over();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
